// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares data BRAM port B between the pipeline MEM stage and an external host
// master, grants one access per cycle, stalls the core when the host wins and
// routes the one-cycle-latency read data back to whichever side issued the read.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN -- when defined, conflicts are
// resolved by alternating winners; otherwise the core has priority and a host
// starvation counter forces a host win after MAX_HOST_WAIT refused cycles.

module dmem_port_arbiter #(
  parameter int unsigned MAX_HOST_WAIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_core_req,
  input  logic [3:0]  i_core_we,
  input  logic [31:0] i_core_addr,
  input  logic [31:0] i_core_wdata,
  output logic        o_core_stall,
  output logic        o_core_rvalid,
  output logic [31:0] o_core_rdata,
  input  logic        i_host_req,
  input  logic [3:0]  i_host_we,
  input  logic [31:0] i_host_addr,
  input  logic [31:0] i_host_wdata,
  output logic        o_host_gnt,
  output logic        o_host_rvalid,
  output logic [31:0] o_host_rdata,
  output logic [3:0]  o_bram_we,
  output logic [31:0] o_bram_addr,
  output logic [31:0] o_bram_di,
  input  logic [31:0] i_bram_do
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_HOST_WAIT);
  localparam logic [3:0] LP_WAIT_SAT = 4'd15;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } rd_owner_e;

  rd_owner_e  r_rd_owner;
  rd_owner_e  w_rd_owner_nxt;
  logic [3:0] r_host_wait;
  logic [3:0] w_host_wait_nxt;
  logic       w_host_first;
  logic       w_host_gnt;
  logic       w_core_gnt;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  typedef enum logic {
    WIN_CORE = 1'b0,
    WIN_HOST = 1'b1
  } winner_e;

  winner_e r_last_winner;
  winner_e w_last_winner_nxt;
`endif

  // Grant decision: a lone requester always wins; on conflict pick by policy.
  // Gated by reset so nothing is granted (and nothing stalls) while in reset.
  always_comb begin
    w_host_first = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    w_host_first = (r_last_winner == WIN_CORE);
`else
    w_host_first = (r_host_wait >= LP_MAX_WAIT);
`endif
    w_host_gnt = i_rst_n & i_host_req & (~i_core_req | w_host_first);
    w_core_gnt = i_rst_n & i_core_req & ~w_host_gnt;
  end

  // BRAM port B mux: drive the winner's access, all zeros when idle.
  always_comb begin
    o_bram_we   = 4'd0;
    o_bram_addr = 32'd0;
    o_bram_di   = 32'd0;
    if (w_host_gnt) begin
      o_bram_we   = i_host_we;
      o_bram_addr = i_host_addr;
      o_bram_di   = i_host_wdata;
    end else if (w_core_gnt) begin
      o_bram_we   = i_core_we;
      o_bram_addr = i_core_addr;
      o_bram_di   = i_core_wdata;
    end
  end

  // Next state: read owner for next cycle, host starvation count, rotation.
  always_comb begin
    w_rd_owner_nxt  = OWN_NONE;
    w_host_wait_nxt = 4'd0;
    if (w_host_gnt && (i_host_we == 4'd0)) begin
      w_rd_owner_nxt = OWN_HOST;
    end else if (w_core_gnt && (i_core_we == 4'd0)) begin
      w_rd_owner_nxt = OWN_CORE;
    end
    if (i_host_req && !w_host_gnt) begin
      w_host_wait_nxt = (r_host_wait == LP_WAIT_SAT) ? r_host_wait : r_host_wait + 4'd1;
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    w_last_winner_nxt = r_last_winner;
    if (i_core_req && i_host_req && (w_host_gnt || w_core_gnt)) begin
      w_last_winner_nxt = w_host_gnt ? WIN_HOST : WIN_CORE;
    end
`endif
  end

  // State registers; reset drops any pending read return.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_owner    <= OWN_NONE;
      r_host_wait   <= 4'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      r_last_winner <= WIN_HOST;
`endif
    end else begin
      r_rd_owner    <= w_rd_owner_nxt;
      r_host_wait   <= w_host_wait_nxt;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      r_last_winner <= w_last_winner_nxt;
`endif
    end
  end

  assign o_host_gnt    = w_host_gnt;
  assign o_core_stall  = i_rst_n & i_core_req & ~w_core_gnt;
  assign o_core_rvalid = (r_rd_owner == OWN_CORE);
  assign o_host_rvalid = (r_rd_owner == OWN_HOST);
  assign o_core_rdata  = (r_rd_owner == OWN_CORE) ? i_bram_do : 32'd0;
  assign o_host_rdata  = (r_rd_owner == OWN_HOST) ? i_bram_do : 32'd0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Directed scenarios followed by random traffic, checked every cycle against a
// behavioural model of the arbitration rules and a reference copy of memory.
// Honours DMEM_ARB_ROUND_ROBIN_EN to select the expected conflict policy.

module tb_dmem_port_arbiter;

  localparam int MAX_WAIT = 8;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam int EXP_GNT_CYCLE = 2;
`else
  localparam int EXP_GNT_CYCLE = MAX_WAIT + 1;
`endif

  logic        clk;
  logic        rstN;
  logic        coreReq;
  logic [3:0]  coreWe;
  logic [31:0] coreAddr;
  logic [31:0] coreWdata;
  logic        coreStall;
  logic        coreRvalid;
  logic [31:0] coreRdata;
  logic        hostReq;
  logic [3:0]  hostWe;
  logic [31:0] hostAddr;
  logic [31:0] hostWdata;
  logic        hostGnt;
  logic        hostRvalid;
  logic [31:0] hostRdata;
  logic [3:0]  bramWe;
  logic [31:0] bramAddr;
  logic [31:0] bramDi;
  logic [31:0] bramDo;

  int testCount;
  int failCount;

  // Reference model state
  int          modelHostWait;
  bit          modelLastHostWon;
  int          modelPendOwner;
  logic [31:0] modelPendData;
  logic [31:0] refMem [256];
  bit          expCoreGnt;
  bit          expHostGnt;

  // BRAM stub memory
  logic [31:0] bramMem [256];
  bit          memReady = 1'b0;

  dmem_port_arbiter #(.MAX_HOST_WAIT(MAX_WAIT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_core_req   (coreReq),
    .i_core_we    (coreWe),
    .i_core_addr  (coreAddr),
    .i_core_wdata (coreWdata),
    .o_core_stall (coreStall),
    .o_core_rvalid(coreRvalid),
    .o_core_rdata (coreRdata),
    .i_host_req   (hostReq),
    .i_host_we    (hostWe),
    .i_host_addr  (hostAddr),
    .i_host_wdata (hostWdata),
    .o_host_gnt   (hostGnt),
    .o_host_rvalid(hostRvalid),
    .o_host_rdata (hostRdata),
    .o_bram_we    (bramWe),
    .o_bram_addr  (bramAddr),
    .o_bram_di    (bramDi),
    .i_bram_do    (bramDo)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] initWord(input int i);
    if (i == 64) return 32'hDEADBEEF;
    return 32'h1234_5678 ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  function automatic logic [31:0] randAddr();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  // Synchronous BRAM port model, read-first, one cycle latency
  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 256; i++) bramMem[i] <= initWord(i);
      memReady <= 1'b1;
      bramDo   <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bramWe[b]) bramMem[bramAddr[9:2]][8*b +: 8] <= bramDi[8*b +: 8];
      end
      bramDo <= bramMem[bramAddr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic [3:0] cWe, input logic [31:0] cAddr,
                               input logic [31:0] cWdata, input logic hReq, input logic [3:0] hWe,
                               input logic [31:0] hAddr, input logic [31:0] hWdata);
    coreReq   = cReq;
    coreWe    = cWe;
    coreAddr  = cAddr;
    coreWdata = cWdata;
    hostReq   = hReq;
    hostWe    = hWe;
    hostAddr  = hAddr;
    hostWdata = hWdata;
  endtask

  task automatic modelReset();
    modelHostWait    = 0;
    modelLastHostWon = 1'b1;
    modelPendOwner   = 0;
    modelPendData    = 32'd0;
  endtask

  task automatic refWrite(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      if (we[b]) refMem[addr[9:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Settle, predict this cycle's outputs from the rules, compare all of them
  task automatic checkOutput(input string tag);
    bit          hostFirst;
    logic [3:0]  eWe;
    logic [31:0] eAddr;
    logic [31:0] eDi;
    #1;
    hostFirst  = 1'b0;
    expHostGnt = 1'b0;
    expCoreGnt = 1'b0;
    eWe        = 4'd0;
    eAddr      = 32'd0;
    eDi        = 32'd0;
    if (rstN) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      hostFirst = !modelLastHostWon;
`else
      hostFirst = (modelHostWait >= MAX_WAIT);
`endif
      if (hostReq && (!coreReq || hostFirst)) begin
        expHostGnt = 1'b1;
        eWe = hostWe; eAddr = hostAddr; eDi = hostWdata;
      end else if (coreReq) begin
        expCoreGnt = 1'b1;
        eWe = coreWe; eAddr = coreAddr; eDi = coreWdata;
      end
    end
    chk({tag, ".host_gnt"}, hostGnt, expHostGnt);
    chk({tag, ".core_stall"}, coreStall, rstN && coreReq && !expCoreGnt);
    chk({tag, ".bram_we"}, bramWe, eWe);
    chk({tag, ".bram_addr"}, bramAddr, eAddr);
    chk({tag, ".bram_di"}, bramDi, eDi);
    chk({tag, ".core_rvalid"}, coreRvalid, modelPendOwner == 1);
    chk({tag, ".core_rdata"}, coreRdata, (modelPendOwner == 1) ? modelPendData : 32'd0);
    chk({tag, ".host_rvalid"}, hostRvalid, modelPendOwner == 2);
    chk({tag, ".host_rdata"}, hostRdata, (modelPendOwner == 2) ? modelPendData : 32'd0);
    chk({tag, ".one_rvalid"}, coreRvalid & hostRvalid, 1'b0);
  endtask

  // Advance one clock and apply the rules' state changes to the model
  task automatic advanceClock();
    @(posedge clk);
    if (!rstN) begin
      modelReset();
    end else begin
      if (hostReq && !expHostGnt) modelHostWait = (modelHostWait < 15) ? modelHostWait + 1 : 15;
      else modelHostWait = 0;
      if (coreReq && hostReq) modelLastHostWon = expHostGnt;
      modelPendOwner = 0;
      if (expHostGnt) begin
        if (hostWe == 4'd0) begin modelPendOwner = 2; modelPendData = refMem[hostAddr[9:2]]; end
        else refWrite(hostAddr, hostWe, hostWdata);
      end else if (expCoreGnt) begin
        if (coreWe == 4'd0) begin modelPendOwner = 1; modelPendData = refMem[coreAddr[9:2]]; end
        else refWrite(coreAddr, coreWe, coreWdata);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int          gntCycle;
    bit          hPend;
    bit          cHold;
    logic        rcReq;
    logic [3:0]  rcWe, rhWe;
    logic [31:0] rcAddr, rcWdata, rhAddr, rhWdata;

    testCount = 0;
    failCount = 0;
    for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
    modelReset();
    rstN = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);

    // Step 1: reset with both sides requesting, all outputs must be zero
    @(negedge clk);
    applyStimulus(1'b1, 4'd0, 32'h100, 32'd0, 1'b1, 4'd0, 32'h40, 32'd0);
    checkOutput("reset");
    advanceClock();
    checkOutput("reset2");
    advanceClock();
    rstN = 1'b1;

    // Step 2: core-only read of 0x100
    applyStimulus(1'b1, 4'd0, 32'h100, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("coreRd");
    chk("coreRd.addr_direct", bramAddr, 32'h100);
    advanceClock();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("coreRd+1");
    chk("coreRd.rdata_direct", coreRdata, 32'hDEADBEEF);
    advanceClock();

    // Step 3: host byte write to 0x40, core idle
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0001, 32'h40, 32'h0000_00AA);
    checkOutput("hostWr");
    chk("hostWr.we_direct", bramWe, 4'b0001);
    advanceClock();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("hostWr+1");
    advanceClock();

    // Step 4: continuous core reads against a held host read
    gntCycle = -1;
    for (int c = 1; c <= 20 && gntCycle < 0; c++) begin
      applyStimulus(1'b1, 4'd0, randAddr(), 32'd0, 1'b1, 4'd0, 32'h300, 32'd0);
      checkOutput("starve");
      if (hostGnt === 1'b1) begin
        gntCycle = c;
        chk("starve.stall_on_gnt", coreStall, 1'b1);
      end
      advanceClock();
    end
    chk("starve.gnt_cycle", gntCycle, EXP_GNT_CYCLE);
    applyStimulus(1'b1, 4'd0, randAddr(), 32'd0, 1'b1, 4'd0, 32'h304, 32'd0);
    checkOutput("starve+1");
    chk("starve.host_rvalid", hostRvalid, 1'b1);
    chk("starve.rewait", hostGnt, 1'b0);
    advanceClock();

    // Step 5: back-to-back host read then core read
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h304, 32'd0);
    checkOutput("b2b.N");
    advanceClock();
    applyStimulus(1'b1, 4'd0, 32'h308, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("b2b.N1");
    chk("b2b.host_word", hostRdata, initWord(193));
    advanceClock();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("b2b.N2");
    chk("b2b.core_word", coreRdata, initWord(194));
    advanceClock();

    // Step 6: reset in the cycle a host read would return
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h80, 32'd0);
    checkOutput("rstMid.N");
    advanceClock();
    applyStimulus(1'b1, 4'd0, 32'h84, 32'd0, 1'b1, 4'd0, 32'h88, 32'd0);
    rstN = 1'b0;
    modelReset();
    checkOutput("rstMid.low");
    chk("rstMid.host_rvalid", hostRvalid, 1'b0);
    advanceClock();
    rstN = 1'b1;
    checkOutput("rstMid.release");
    chk("rstMid.core_first", coreStall, 1'b0);
    advanceClock();
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h88, 32'd0);
    checkOutput("rstMid.hostDone");
    advanceClock();

    // Step 7: random traffic obeying both handshakes
    hPend = 1'b0;
    cHold = 1'b0;
    rcReq = 1'b0; rcWe = 4'd0; rcAddr = 32'd0; rcWdata = 32'd0;
    rhWe = 4'd0; rhAddr = 32'd0; rhWdata = 32'd0;
    for (int i = 0; i < 300; i++) begin
      if (!hPend) begin
        hPend   = ($urandom_range(0, 2) != 0);
        rhWe    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        rhAddr  = randAddr();
        rhWdata = $urandom();
      end
      if (!cHold) begin
        rcReq   = ($urandom_range(0, 9) < 7);
        rcWe    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        rcAddr  = randAddr();
        rcWdata = $urandom();
      end
      applyStimulus(rcReq, rcWe, rcAddr, rcWdata, hPend, rhWe, rhAddr, rhWdata);
      checkOutput("rand");
      if (expHostGnt) hPend = 1'b0;
      cHold = rcReq && !expCoreGnt;
      advanceClock();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
